// File: rtl/lstm_pkg.sv
// Shared LSTM sizing constants, weight-image size helpers and the loader FSM state type.
package lstm_pkg;

  localparam int INPUT_SIZE  = 96;
  localparam int HIDDEN_SIZE = 512;
  localparam int QZ          = 16;

  // Four gates, each with an input block (W_ih) and a recurrent block (W_hh).
  function automatic int total_words(input int in_sz, input int hid_sz);
    return 4 * hid_sz * (in_sz + hid_sz);
  endfunction

  function automatic int addr_width(input int in_sz, input int hid_sz);
    return $clog2(total_words(in_sz, hid_sz));
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } ws_state_t;

endpackage

// File: rtl/ws_skid_fifo.sv
// Small synchronous FIFO holding returned weight words until weight_save accepts them.
module ws_skid_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // An empty buffer presents zero so the write port idles at its reset value.
  assign dout  = empty ? '0 : mem[rd_ptr];

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/weight_stream_loader.sv
// Streams the LSTM weight image from a synchronous-read memory into weight_save,
// hiding the read latency behind a credit-controlled skid buffer.
//   state  | meaning
//   IDLE   | waiting for start, no reads
//   STREAM | issuing reads while credit allows
//   DRAIN  | all reads issued, waiting for returns and buffer to empty
//   DONE   | one-cycle end-of-pass, restart if continuous
module weight_stream_loader #(
  parameter  int INPUT_SIZE  = lstm_pkg::INPUT_SIZE,
  parameter  int HIDDEN_SIZE = lstm_pkg::HIDDEN_SIZE,
  parameter  int QZ          = lstm_pkg::QZ,
  parameter  int RD_LAT      = 2,
  localparam int TOTAL_WORDS = lstm_pkg::total_words(INPUT_SIZE, HIDDEN_SIZE),
  localparam int ADDR_W      = lstm_pkg::addr_width(INPUT_SIZE, HIDDEN_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [QZ-1:0]     mem_rdata,
  input  logic              fifo_ready,
  output logic              wr_valid,
  output logic [QZ-1:0]     wr_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  import lstm_pkg::*;

  localparam int DEPTH = RD_LAT + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(RD_LAT + 1);
  localparam int SUM_W = CNT_W + 1;

  ws_state_t         state;
  ws_state_t         state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] rd_pipe;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              last_addr;
  logic [SUM_W-1:0]  credit_used;

  assign push      = rd_pipe[RD_LAT-1];
  assign pop       = !fifo_empty && fifo_ready;
  assign wr_valid  = pop;
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign last_addr = (addr == ADDR_W'(TOTAL_WORDS - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + INF_W'(rd_pipe[i]);
  end

  // Words already owed to the buffer plus words in it, net of this cycle's pop.
  assign credit_used = SUM_W'(inflight) + SUM_W'(fifo_count) - SUM_W'(pop);

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        mem_rd_en = (credit_used < SUM_W'(DEPTH));
        if (mem_rd_en && last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (inflight == '0 && (fifo_empty || (fifo_count == CNT_W'(1) && pop)))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = continuous ? STREAM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      rd_pipe  <= '0;
      pass_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rd_pipe <= RD_LAT'({rd_pipe, mem_rd_en});
      // Wrapping on the final issue leaves the address at 0 for the next pass.
      if (mem_rd_en) addr <= last_addr ? '0 : addr + ADDR_W'(1);
      if (state == DONE) pass_cnt <= pass_cnt + 16'd1;
    end
  end

  ws_skid_fifo #(
    .WIDTH(QZ),
    .DEPTH(DEPTH)
  ) u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (mem_rdata),
    .dout (wr_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule
